paddle_move_ctrl: RTL
=====================

// Module: paddle_move_ctrl
// PURPOSE
//  Sequences the paddle position datapath: debounces the raw left/right buttons, resolves
//  conflicts, and issues single-cycle move-step pulses aligned to the frame tick with
//  keyboard-style auto-repeat. Pulses are suppressed at the playfield edges.
//  Sits between the board button pins and the paddle position register; one step pulse = one 10 px move.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable clk cycles required to accept a button level change
//  REPEAT_DELAY     15      frame ticks from first step to first auto-repeat step
//  REPEAT_RATE      2       frame ticks between auto-repeat steps (>=1)
//  MIN_POS          10      left limit; no left step when pos <= MIN_POS
//  MAX_POS          530     right limit; no right step when pos >= MAX_POS
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  btn_left    in   1   raw left button, asynchronous to clk, may bounce
//  btn_right   in   1   raw right button, asynchronous to clk, may bounce
//  frame_tick  in   1   one-cycle pulse per video frame
//  pos         in   10  current paddle x position from the position register
//  move_left   out  1   one-cycle step-left pulse (registered)
//  move_right  out  1   one-cycle step-right pulse (registered)
//  dir         out  2   latched direction: 00 none, 01 left, 10 right
//  at_limit    out  1   high while dir points at an edge already reached
// BEHAVIOUR
//  - Reset (async): all sync flops, debounce counters, FSM=IDLE, frame counter=0, all outputs 0.
//  - Input path, per button: 2-flop synchroniser, then debouncer. The debounced level flips only
//    after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any shorter
//    glitch resets the counter. Counter width is $clog2(DEBOUNCE_CYCLES+1).
//  - Request decode from debounced levels: only L -> LEFT; only R -> RIGHT; none or both -> NONE.
//  - FSM states IDLE, ARMED, DELAY, REPEAT; dir is latched on entry to ARMED.
//    IDLE:   request LEFT/RIGHT -> ARMED.
//    ARMED:  on frame_tick: fire, load cnt=REPEAT_DELAY -> DELAY.
//    DELAY:  on frame_tick: cnt==1 -> fire, load cnt=REPEAT_RATE -> REPEAT; otherwise cnt--.
//    REPEAT: on frame_tick: cnt==1 -> fire, reload REPEAT_RATE; otherwise cnt--.
//  - Priority, highest first, evaluated in the same cycle:
//    1. request NONE in any non-IDLE state -> IDLE, dir=00, no fire.
//    2. request differs from latched dir -> ARMED with new dir, no fire.
//    3. normal transitions above.
//    A release or direction change coincident with frame_tick therefore produces no step.
//  - Fire: move_left <= (dir==01 && pos>MIN_POS) and move_right <= (dir==10 && pos<MAX_POS).
//    pos is sampled in the fire cycle; the pulse appears on the next clk edge and lasts exactly 1 cycle.
//    move_left and move_right are never high together.
//  - A gated fire (at the limit) still advances the repeat schedule and emits no pulse.
//  - at_limit is combinational from the registered dir and live pos.
//  - Latency: first step pulse = 1 cycle after the first frame_tick following debounced acceptance.
// TESTING
//  Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2, frame_tick every 10 clk.
//  1. Reset mid-hold (btn_left held, reset pulsed) -> outputs 0 immediately; no pulse until re-debounced
//     and next frame_tick.
//  2. btn_left bounce 1-0-1 with 2-cycle pulses, then held; pos=270 -> no acceptance during bounce.
//     Then exactly one move_left 1 cycle after the first tick; next pulses after ticks 4, 6, 8 counted
//     from the first tick.
//  3. Both buttons held -> zero pulses and dir=00; release btn_right -> left sequence starts
//     from ARMED.
//  4. btn_right held, pos=530 -> no move_right pulses, at_limit=1, dir=10; pos forced to 520 ->
//     next scheduled fire produces a move_right pulse.
//  5. Switch left->right during REPEAT, with debounced change landing on a frame_tick cycle -> no
//     pulse that tick; first move_right comes 1 cycle after the following tick.
//  6. Release coincident with frame_tick in REPEAT at cnt==1 -> no pulse, FSM=IDLE, dir=00
//     next cycle.

Source files
------------

// File: rtl/paddle_move_ctrl.sv
// Paddle step sequencer: synchronises and debounces the two raw buttons, then issues
// frame-aligned, auto-repeating single-cycle step pulses that stop at the playfield edges.
//
// state  | meaning
// IDLE   | no direction requested, dir = none
// ARMED  | direction latched, waiting for the first frame tick to take the first step
// DELAY  | first step taken, counting frame ticks down to the first auto-repeat step
// REPEAT | auto-repeating, one step every REPEAT_RATE frame ticks
module paddle_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 15,
    parameter int REPEAT_RATE     = 2,
    parameter int MIN_POS         = 10,
    parameter int MAX_POS         = 530
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic [9:0] pos,
    output logic       move_left,
    output logic       move_right,
    output logic [1:0] dir,
    output logic       at_limit
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] CNT_DLY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] CNT_RATE = RPT_W'(REPEAT_RATE);
    localparam logic [RPT_W-1:0] CNT_ONE  = RPT_W'(1);
    localparam logic [9:0]       MIN_P    = 10'(MIN_POS);
    localparam logic [9:0]       MAX_P    = 10'(MAX_POS);

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_REPEAT
    } state_t;

    // bit 0 = left, bit 1 = right throughout the input path
    logic [1:0]      btn_raw;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      btn_deb;
    logic [DB_W-1:0] db_cnt [2];

    dir_t             req;
    state_t           state, state_n;
    dir_t             dir_q, dir_n;
    logic [RPT_W-1:0] cnt, cnt_n;
    logic             fire;

    assign btn_raw = {btn_right, btn_left};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt  <= '{default: '0};
            btn_deb <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == btn_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_deb[i] <= sync_b[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        case (btn_deb)
            2'b01:   req = DIR_LEFT;
            2'b10:   req = DIR_RIGHT;
            default: req = DIR_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            dir_q      <= DIR_NONE;
            cnt        <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            state      <= state_n;
            dir_q      <= dir_n;
            cnt        <= cnt_n;
            move_left  <= fire && (dir_q == DIR_LEFT)  && (pos > MIN_P);
            move_right <= fire && (dir_q == DIR_RIGHT) && (pos < MAX_P);
        end
    end

    // Release beats a direction change, which beats the repeat schedule.
    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        cnt_n   = cnt;
        fire    = 1'b0;
        if (state == S_IDLE) begin
            if (req != DIR_NONE) begin
                state_n = S_ARMED;
                dir_n   = req;
            end
        end else if (req == DIR_NONE) begin
            state_n = S_IDLE;
            dir_n   = DIR_NONE;
        end else if (req != dir_q) begin
            state_n = S_ARMED;
            dir_n   = req;
        end else if (frame_tick) begin
            case (state)
                S_ARMED: begin
                    fire    = 1'b1;
                    cnt_n   = CNT_DLY;
                    state_n = S_DELAY;
                end
                S_DELAY, S_REPEAT: begin
                    if (cnt == CNT_ONE) begin
                        fire    = 1'b1;
                        cnt_n   = CNT_RATE;
                        state_n = S_REPEAT;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign dir      = dir_q;
    assign at_limit = ((dir_q == DIR_LEFT)  && (pos <= MIN_P)) ||
                      ((dir_q == DIR_RIGHT) && (pos >= MAX_P));

endmodule
